// File: rtl/serial_pkg.sv
// Shared serial-subsystem definitions: standard baud table, the autobaud state
// encoding, and nominal bit-period arithmetic.
package serial_pkg;

    localparam int NUM_BAUD_RATES = 10;

    localparam int unsigned BAUD_TABLE [NUM_BAUD_RATES] = '{
        300, 1200, 2400, 4800, 9600, 14400, 19200, 38400, 57600, 115200
    };

    localparam int unsigned DEFAULT_BAUD = 9600;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        MATCH,
        APPLY,
        LOCKED
    } autobaud_state_e;

    function automatic int unsigned nominal_period(input int unsigned clk_hz,
                                                   input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses that line up with the
// first cycle of the new synchronized level.
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= RESET_VAL;
            q    <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            q    <= s1;
            rise <= s1 & ~q;
            fall <= ~s1 & q;
        end
    end

endmodule

// File: rtl/uart_autobaud.sv
// Autobaud: times the start bit of a 0x55 sync char and applies the nearest
// standard rate. UART_AUTOBAUD_CONFIRM_EN requires two agreeing measurements.
module uart_autobaud
    import serial_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 100_000_000,
    parameter int unsigned IDLE_MIN      = 16,
    parameter int unsigned RST_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx,
    output logic [17:0] baud_rate,
    output logic        gen_rst,
    output logic        busy,
    output logic        locked,
    output logic        err
);

    localparam int unsigned P300   = nominal_period(CLOCK_FREQ_HZ, BAUD_TABLE[0]);
    localparam int unsigned LIMIT  = P300 + P300 / 8;
    localparam int          CNT_W  = $clog2(LIMIT) + 1;
    localparam int          IDLE_W = $clog2(IDLE_MIN + 1);
    localparam int          RST_W  = $clog2(RST_CYCLES + 1);
    localparam int          IDX_W  = $clog2(NUM_BAUD_RATES);

    typedef logic [CNT_W-1:0] cnt_t;

    // Tolerance windows are elaboration constants; no runtime divider.
    cnt_t lo_tab [NUM_BAUD_RATES];
    cnt_t hi_tab [NUM_BAUD_RATES];

    for (genvar g = 0; g < NUM_BAUD_RATES; g++) begin : g_tab
        localparam int unsigned P = nominal_period(CLOCK_FREQ_HZ, BAUD_TABLE[g]);
        assign lo_tab[g] = cnt_t'(P - P / 8);
        assign hi_tab[g] = cnt_t'(P + P / 8);
    end

    logic rxs, rx_rise, rx_fall;

    sync_edge u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rxs),
        .rise (rx_rise),
        .fall (rx_fall)
    );

    autobaud_state_e    state, state_n;
    logic [IDLE_W-1:0]  idle_cnt, idle_n;
    cnt_t               meas_cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n, hit_idx, hit_n, sel_idx;
    logic               found, found_n, in_range, sel_ok;
    logic [RST_W-1:0]   rst_cnt, rcnt_n;
    logic               err_q, err_n;
    logic [17:0]        baud_q, baud_n;
`ifdef UART_AUTOBAUD_CONFIRM_EN
    logic               have_first, have_n;
    logic [IDX_W-1:0]   first_idx, first_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idle_cnt   <= '0;
            meas_cnt   <= '0;
            idx        <= '0;
            hit_idx    <= '0;
            found      <= 1'b0;
            rst_cnt    <= '0;
            err_q      <= 1'b0;
            baud_q     <= 18'(DEFAULT_BAUD);
`ifdef UART_AUTOBAUD_CONFIRM_EN
            have_first <= 1'b0;
            first_idx  <= '0;
`endif
        end else begin
            state      <= state_n;
            idle_cnt   <= idle_n;
            meas_cnt   <= cnt_n;
            idx        <= idx_n;
            hit_idx    <= hit_n;
            found      <= found_n;
            rst_cnt    <= rcnt_n;
            err_q      <= err_n;
            baud_q     <= baud_n;
`ifdef UART_AUTOBAUD_CONFIRM_EN
            have_first <= have_n;
            first_idx  <= first_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        idle_n   = idle_cnt;
        cnt_n    = meas_cnt;
        idx_n    = idx;
        hit_n    = hit_idx;
        found_n  = found;
        rcnt_n   = rst_cnt;
        err_n    = 1'b0;
        baud_n   = baud_q;
        in_range = (meas_cnt >= lo_tab[idx]) && (meas_cnt <= hi_tab[idx]);
        // The final scan cycle can still produce the first hit.
        sel_ok   = found | in_range;
        sel_idx  = found ? hit_idx : idx;
`ifdef UART_AUTOBAUD_CONFIRM_EN
        have_n   = have_first;
        first_n  = first_idx;
`endif
        case (state)
            IDLE, LOCKED: begin
                if (start) begin
                    state_n = ARM;
                    idle_n  = '0;
`ifdef UART_AUTOBAUD_CONFIRM_EN
                    have_n  = 1'b0;
`endif
                end
            end
            ARM: begin
                if (rx_fall && idle_cnt >= IDLE_W'(IDLE_MIN)) begin
                    state_n = MEASURE;
                    cnt_n   = cnt_t'(1);
                    idle_n  = '0;
                end else if (!rxs) begin
                    idle_n = '0;
                end else if (idle_cnt < IDLE_W'(IDLE_MIN)) begin
                    idle_n = idle_cnt + 1'b1;
                end
            end
            MEASURE: begin
                if (rx_rise) begin
                    state_n = MATCH;
                    idx_n   = '0;
                    found_n = 1'b0;
                end else if (meas_cnt >= cnt_t'(LIMIT)) begin
                    err_n   = 1'b1;
                    state_n = ARM;
                    idle_n  = '0;
`ifdef UART_AUTOBAUD_CONFIRM_EN
                    have_n  = 1'b0;
`endif
                end else if (!rxs) begin
                    cnt_n = meas_cnt + 1'b1;
                end
            end
            MATCH: begin
                idx_n = idx + 1'b1;
                if (in_range && !found) begin
                    found_n = 1'b1;
                    hit_n   = idx;
                end
                if (idx == IDX_W'(NUM_BAUD_RATES - 1)) begin
                    state_n = ARM;
                    idle_n  = '0;
                    if (!sel_ok) begin
                        err_n = 1'b1;
`ifdef UART_AUTOBAUD_CONFIRM_EN
                        have_n = 1'b0;
                    end else if (!have_first) begin
                        have_n  = 1'b1;
                        first_n = sel_idx;
                    end else if (sel_idx != first_idx) begin
                        err_n  = 1'b1;
                        have_n = 1'b0;
`endif
                    end else begin
                        state_n = APPLY;
                        rcnt_n  = '0;
                        baud_n  = 18'(BAUD_TABLE[sel_idx]);
                    end
                end
            end
            APPLY: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) state_n = LOCKED;
                else                                   rcnt_n  = rst_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign baud_rate = baud_q;
    assign gen_rst   = (state == APPLY);
    assign busy      = (state == ARM) || (state == MEASURE) ||
                       (state == MATCH) || (state == APPLY);
    // Drop locked in the cycle start is seen rather than one cycle later.
    assign locked    = (state == LOCKED) && !start;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud. The DUT runs with a 10 MHz nominal clock so
// the line-break timeout (37499 cycles) stays short; windows are P +/- P/8.
module tb_uart_autobaud;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx = 1'b1;
    logic [17:0] baud_rate;
    logic        gen_rst, busy, locked, err;

    int checks = 0;
    int errors = 0;

    uart_autobaud #(.CLOCK_FREQ_HZ(10_000_000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx       (rx),
        .baud_rate(baud_rate),
        .gen_rst  (gen_rst),
        .busy     (busy),
        .locked   (locked),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // start pulse, 20 idle-high cycles, k low cycles, then rx returns high.
    task automatic measure(input int k);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(20);
        rx = 1'b0; cyc(k); rx = 1'b1;
    endtask

    // Samples n = 1..16 after rx rises; synchronized rise lands at n = 2 (E),
    // so APPLY is visible at n = 13,14 and LOCKED from n = 15.
    task automatic observe(output logic [16:0] gp, output logic [16:0] ep,
                           output logic [17:0] b13);
        gp = '0; ep = '0; b13 = '0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            gp[n] = gen_rst;
            ep[n] = err;
            if (n == 13) b13 = baud_rate;
        end
    endtask

    typedef struct {
        string name;
        int    k;
        bit    lock;
        int    baud;
    } vec_t;

    localparam int NV = 11;
    localparam logic [16:0] GEN_WIN = 17'h06000;
    localparam logic [16:0] ERR_AT  = 17'h02000;

    vec_t        vecs [NV];
    logic [16:0] gp, ep;
    logic [17:0] b13;
    int          err_cnt, gen_cnt, first_err;

    initial begin
        vecs[0]  = '{name: "b115k_hi",    k: 96,   lock: 1'b1, baud: 115200};
        vecs[1]  = '{name: "b115k_over",  k: 97,   lock: 1'b0, baud: 115200};
        vecs[2]  = '{name: "b9600_nom",   k: 1042, lock: 1'b1, baud: 9600};
        vecs[3]  = '{name: "b115k_lo",    k: 76,   lock: 1'b1, baud: 115200};
        vecs[4]  = '{name: "below_115k",  k: 75,   lock: 1'b0, baud: 115200};
        vecs[5]  = '{name: "b57600",      k: 173,  lock: 1'b1, baud: 57600};
        vecs[6]  = '{name: "gap_57k_38k", k: 200,  lock: 1'b0, baud: 57600};
        vecs[7]  = '{name: "b9600_lo",    k: 911,  lock: 1'b1, baud: 9600};
        vecs[8]  = '{name: "above_9600",  k: 1172, lock: 1'b0, baud: 9600};
        vecs[9]  = '{name: "b1200",       k: 8333, lock: 1'b1, baud: 1200};
        vecs[10] = '{name: "b4800",       k: 2083, lock: 1'b1, baud: 4800};

        cyc(3);
        chk("rst_baud",   baud_rate, 9600);
        chk("rst_genrst", gen_rst, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_err",    err, 0);
        rst_n = 1'b1;
        cyc(3);

        // Line break: timeout when the count reaches 37499.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(20);
        rx = 1'b0;
        err_cnt = 0; gen_cnt = 0; first_err = 0;
        for (int n = 1; n <= 40000; n++) begin
            @(negedge clk);
            if (err) begin
                err_cnt++;
                if (first_err == 0) first_err = n;
            end
            if (gen_rst) gen_cnt++;
        end
        rx = 1'b1;
        chk("break_err_count", err_cnt, 1);
        chk("break_err_time",  first_err, 37502);
        chk("break_genrst",    gen_cnt, 0);
        chk("break_baud",      baud_rate, 9600);
        chk("break_busy",      busy, 1);

        for (int i = 0; i < NV; i++) begin
`ifdef UART_AUTOBAUD_CONFIRM_EN
            measure(vecs[i].k);
            cyc(16);
`endif
            measure(vecs[i].k);
            observe(gp, ep, b13);
            chk({vecs[i].name, "_genrst"}, gp, vecs[i].lock ? GEN_WIN : 17'h0);
            chk({vecs[i].name, "_err"},    ep, vecs[i].lock ? 17'h0 : ERR_AT);
            if (vecs[i].lock) chk({vecs[i].name, "_baud_apply"}, b13, vecs[i].baud);
            chk({vecs[i].name, "_baud"},   baud_rate, vecs[i].baud);
            chk({vecs[i].name, "_locked"}, locked, vecs[i].lock);
            chk({vecs[i].name, "_busy"},   busy, !vecs[i].lock);
        end

        // Falling edge too soon after start is ignored.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        rx = 1'b0; cyc(173); rx = 1'b1;
        observe(gp, ep, b13);
        chk("guard_genrst", gp, 0);
        chk("guard_err",    ep, 0);
        chk("guard_busy",   busy, 1);
        chk("guard_locked", locked, 0);
        chk("guard_baud",   baud_rate, 4800);

        // start during MEASURE is ignored; 1042-cycle start bit still locks 9600.
`ifdef UART_AUTOBAUD_CONFIRM_EN
        measure(1042);
        cyc(16);
`endif
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(20);
        rx = 1'b0; cyc(500);
        chk("meas_busy", busy, 1);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(541); rx = 1'b1;
        observe(gp, ep, b13);
        chk("meas_start_genrst", gp, GEN_WIN);
        chk("meas_start_baud",   b13, 9600);
        chk("meas_start_locked", locked, 1);

        // Reset in the middle of the gen_rst window.
`ifdef UART_AUTOBAUD_CONFIRM_EN
        measure(173);
        cyc(16);
`endif
        measure(173);
        cyc(13);
        chk("apply_genrst_high", gen_rst, 1);
        rst_n = 1'b0;
        #1;
        chk("apply_rst_genrst", gen_rst, 0);
        chk("apply_rst_locked", locked, 0);
        chk("apply_rst_busy",   busy, 0);
        chk("apply_rst_baud",   baud_rate, 9600);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

`ifdef UART_AUTOBAUD_CONFIRM_EN
        // Disagreeing confirmation: 57600 then 115200.
        measure(173);
        cyc(16);
        measure(86);
        observe(gp, ep, b13);
        chk("confirm_mismatch_genrst", gp, 0);
        chk("confirm_mismatch_err",    ep, ERR_AT);
        chk("confirm_mismatch_locked", locked, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
